// File: rtl/axi_lite_master_if.sv
// Core-side request/response and 5-channel AXI-lite bus signals for axi_lite_master.
// The master modport is the initiator's view; slave is the core + responder side.
interface axi_lite_master_if #(
   parameter int unsigned DATA_LEN  = 32,
   parameter int unsigned STORB_LEN = 4,
   parameter int unsigned ADDR_LEN  = 32
);
   logic                 req_valid;
   logic                 req_ready;
   logic                 req_wen;
   logic [ADDR_LEN-1:0]  req_addr;
   logic [DATA_LEN-1:0]  req_wdata;
   logic [STORB_LEN-1:0] req_wmask;
   logic                 resp_valid;
   logic                 resp_ready;
   logic [DATA_LEN-1:0]  resp_rdata;
   logic                 resp_err;

   logic                 awvalid;
   logic                 awready;
   logic [ADDR_LEN-1:0]  waddr;
   logic                 wvalid;
   logic                 wready;
   logic [DATA_LEN-1:0]  wdata;
   logic [STORB_LEN-1:0] wstrob;
   logic                 bvalid;
   logic                 bready;
   logic [2:0]           bresp;
   logic                 arvalid;
   logic                 arready;
   logic [ADDR_LEN-1:0]  raddr;
   logic                 rvalid;
   logic                 rready;
   logic [DATA_LEN-1:0]  rdata;
   logic [2:0]           rresp;

   modport master (
      input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output awvalid, waddr, wvalid, wdata, wstrob, bready, arvalid, raddr, rready
   );

   modport slave (
      output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  awvalid, waddr, wvalid, wdata, wstrob, bready, arvalid, raddr, rready
   );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-lite initiator: turns one core load/store into AR/R or AW/W/B
// and hands read data plus error status back to the core. All bus outputs are registered.
module axi_lite_master #(
   parameter int unsigned DATA_LEN  = 32,
   parameter int unsigned STORB_LEN = 4,
   parameter int unsigned ADDR_LEN  = 32
) (
   input logic                clk,
   input logic                rst_n,
   axi_lite_master_if.master  bus
);

   typedef enum logic [2:0] {StIdle, StRdAddr, StRdData, StWr, StWrResp, StResp} state_e;

   state_e               state_q, state_d;
   logic                 awvalid_q, awvalid_d;
   logic                 wvalid_q, wvalid_d;
   logic                 arvalid_q, arvalid_d;
   logic                 bready_q, bready_d;
   logic                 rready_q, rready_d;
   logic                 resp_valid_q, resp_valid_d;
   logic                 resp_err_q, resp_err_d;
   logic                 aw_done_q, aw_done_d;
   logic                 w_done_q, w_done_d;
   logic [ADDR_LEN-1:0]  waddr_q, waddr_d;
   logic [ADDR_LEN-1:0]  raddr_q, raddr_d;
   logic [DATA_LEN-1:0]  wdata_q, wdata_d;
   logic [STORB_LEN-1:0] wstrob_q, wstrob_d;
   logic [DATA_LEN-1:0]  resp_rdata_q, resp_rdata_d;

   logic ar_hs, r_hs, aw_hs, w_hs, b_hs, resp_hs;
   logic aw_all, w_all;

   assign ar_hs   = arvalid_q & bus.arready;
   assign r_hs    = rready_q & bus.rvalid;
   assign aw_hs   = awvalid_q & bus.awready;
   assign w_hs    = wvalid_q & bus.wready;
   assign b_hs    = bready_q & bus.bvalid;
   assign resp_hs = resp_valid_q & bus.resp_ready;
   // Include this cycle's handshake so simultaneous AW/W completion is not delayed.
   assign aw_all  = aw_done_q | aw_hs;
   assign w_all   = w_done_q | w_hs;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         arvalid_q    <= 1'b0;
         bready_q     <= 1'b0;
         rready_q     <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
         waddr_q      <= '0;
         raddr_q      <= '0;
         wdata_q      <= '0;
         wstrob_q     <= '0;
         resp_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         awvalid_q    <= awvalid_d;
         wvalid_q     <= wvalid_d;
         arvalid_q    <= arvalid_d;
         bready_q     <= bready_d;
         rready_q     <= rready_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
         waddr_q      <= waddr_d;
         raddr_q      <= raddr_d;
         wdata_q      <= wdata_d;
         wstrob_q     <= wstrob_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (bus.req_valid) state_d = bus.req_wen ? StWr : StRdAddr;
         StRdAddr: if (ar_hs) state_d = StRdData;
         StRdData: if (r_hs) state_d = StResp;
         StWr:     if (aw_all && w_all) state_d = StWrResp;
         StWrResp: if (b_hs) state_d = StResp;
         StResp:   if (resp_hs) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      awvalid_d    = awvalid_q;
      wvalid_d     = wvalid_q;
      arvalid_d    = arvalid_q;
      bready_d     = bready_q;
      rready_d     = rready_q;
      resp_valid_d = resp_valid_q;
      resp_err_d   = resp_err_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;
      waddr_d      = waddr_q;
      raddr_d      = raddr_q;
      wdata_d      = wdata_q;
      wstrob_d     = wstrob_q;
      resp_rdata_d = resp_rdata_q;
      unique case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               if (bus.req_wen) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
                  waddr_d   = bus.req_addr;
                  wdata_d   = bus.req_wdata;
                  wstrob_d  = bus.req_wmask;
               end else begin
                  arvalid_d = 1'b1;
                  raddr_d   = bus.req_addr;
               end
            end
         end
         StRdAddr: begin
            if (ar_hs) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
            end
         end
         StRdData: begin
            if (r_hs) begin
               resp_rdata_d = bus.rdata;
               resp_err_d   = |bus.rresp;
               rready_d     = 1'b0;
               resp_valid_d = 1'b1;
            end
         end
         StWr: begin
            if (aw_hs) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (w_hs) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if (aw_all && w_all) bready_d = 1'b1;
         end
         StWrResp: begin
            if (b_hs) begin
               resp_err_d   = |bus.bresp;
               resp_rdata_d = '0;
               bready_d     = 1'b0;
               resp_valid_d = 1'b1;
            end
         end
         StResp: begin
            if (resp_hs) resp_valid_d = 1'b0;
         end
         default: ;
      endcase
   end

   assign bus.req_ready  = (state_q == StIdle);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.awvalid    = awvalid_q;
   assign bus.waddr      = waddr_q;
   assign bus.wvalid     = wvalid_q;
   assign bus.wdata      = wdata_q;
   assign bus.wstrob     = wstrob_q;
   assign bus.bready     = bready_q;
   assign bus.arvalid    = arvalid_q;
   assign bus.raddr      = raddr_q;
   assign bus.rready     = rready_q;

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Bus initiator that drives the 5-channel AXI-lite-style interface used by the `sram` responder; it is the other end of that link.
- Converts one single-beat load/store request from the core side into AR/R or AW/W/B transactions.
- Returns read data and response status to the requester.
- Sits between the LSU/IFU and the memory responder. Exactly one transaction is outstanding at a time.

Parameters:
- DATA_LEN, 32, data width of W/R channels and request data.
- STORB_LEN, 4, write strobe width (DATA_LEN/8).
- ADDR_LEN, 32, address width.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  core request valid
- req_ready  output  1  master can accept a request
- req_wen  input  1  1 = write, 0 = read
- req_addr  input  ADDR_LEN  request address
- req_wdata  input  DATA_LEN  write data
- req_wmask  input  STORB_LEN  write byte strobes
- resp_valid  output  1  response available to core
- resp_ready  input  1  core consumes response
- resp_rdata  output  DATA_LEN  read data (0 for writes)
- resp_err  output  1  1 if rresp/bresp was nonzero
- awvalid  output  1  write address valid
- awready  input  1  write address ready
- waddr  output  ADDR_LEN  write address
- wvalid  output  1  write data valid
- wready  input  1  write data ready
- wdata  output  DATA_LEN  write data
- wstrob  output  STORB_LEN  write strobes
- bvalid  input  1  write response valid
- bready  output  1  write response ready
- bresp  input  3  write response code, 3'b000 = OK
- arvalid  output  1  read address valid
- arready  input  1  read address ready
- raddr  output  ADDR_LEN  read address
- rvalid  input  1  read data valid
- rready  output  1  read data ready
- rdata  input  DATA_LEN  read data
- rresp  input  3  read response code, 3'b000 = OK

Behaviour:
- Reset (asynchronous, immediate regardless of state):
  - state = IDLE.
  - awvalid, wvalid, arvalid, bready, rready, resp_valid, resp_err = 0.
  - waddr, raddr, wdata, wstrob, resp_rdata = 0.
  - An in-flight bus transaction is abandoned; no recovery.
- All bus and response outputs are registered. req_ready = (state==IDLE), and is combinational from state only.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, RESP.
- IDLE:
  - On req_valid: latch addr/wdata/wmask.
  - If req_wen: go to WR, asserting awvalid=1 and wvalid=1 the next cycle.
  - Else: go to RD_ADDR, asserting arvalid=1.
- RD_ADDR:
  - arvalid and raddr are held stable until arready.
  - On arvalid&arready: arvalid←0, rready←1, go to RD_DATA.
- RD_DATA:
  - On rvalid&rready: resp_rdata←rdata, resp_err←|rresp, rready←0, resp_valid←1, go to RESP.
- WR:
  - awvalid and wvalid drop independently on their own handshakes.
  - Internal flags aw_done and w_done record completed handshakes.
  - Both handshakes in the same cycle is legal.
  - When both are done (counting the current cycle): bready←1, go to WR_RESP.
  - waddr/wdata/wstrob are held stable until their own handshake.
- WR_RESP:
  - On bvalid&bready: resp_err←|bresp, resp_rdata←0, bready←0, resp_valid←1, go to RESP.
- RESP:
  - resp_valid, resp_rdata and resp_err are held until resp_ready.
  - On resp_valid&resp_ready: resp_valid←0, go to IDLE.
  - The next request is accepted no earlier than the following cycle.
- Stray inputs: rvalid outside RD_DATA and bvalid outside WR_RESP are ignored, since rready/bready are 0.
- Latency against a zero-wait responder:
  - Read: request accepted at cycle 0 → arvalid cycle 1 → rvalid cycle 2 → resp_valid cycle 3.
  - Write: same timing, with bvalid at cycle 2.
- No request is accepted while busy. req_* inputs are sampled only in IDLE.

Test Plan:
- Read, zero-wait responder: req read addr 0x8000_0000, memory returns 0xDEADBEEF/rresp 0 → arvalid for exactly 1 cycle, resp_valid at cycle 3 with resp_rdata=0xDEADBEEF, resp_err=0.
- Write, staggered ready: awready delayed 3 cycles, wready immediate; addr 0x8000_0010, data 0x12345678, mask 4'b0011 → wvalid drops after 1 cycle, awvalid holds 3 cycles with stable waddr, bready rises only after both handshakes, resp_err=0.
- Error response: read returning rresp=3'b010 → resp_err=1; write returning bresp=3'b010 → resp_err=1, resp_rdata=0.
- Backpressure on core side: resp_ready held 0 for 5 cycles → resp_valid and data stable, req_ready=0 throughout, no new bus valids asserted.
- Back-to-back: read then write, each with resp_ready=1 → second request is accepted only in IDLE, and bus-channel ordering is correct.
- Reset mid-transaction: assert rst_n=0 during WR_RESP → all valids/readies are 0 immediately; after release, req_ready=1 and a fresh read completes normally.
